led_pwm_multi: RTL and testbench

- Multi-channel successor to the single-channel LED PWM.
- Drives nr_of_channels_p LED outputs from one shared free-running period counter.
- Per-channel duty and enable are shadowed and updated only at period boundaries, so outputs never glitch.
- Sits between the control-register block and the LED pins; one instance serves a whole LED bank.

---
 rtl/led_pwm_multi.sv | 113 +++++++++++
 tb/tb_led_pwm_multi.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_multi.sv
// led_pwm_multi: N-channel LED PWM sharing one period counter; duty/enable shadowed at period boundaries.
// Optional duty fading toward the target at each boundary when LED_PWM_FADE_EN is defined.
`default_nettype none

module led_pwm_multi #(
  parameter int counter_width_p  = 8,
  parameter int nr_of_channels_p = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  output logic [nr_of_channels_p-1:0]                 pwm,
  input  logic [nr_of_channels_p*counter_width_p-1:0] cr_pwm_duty,
  input  logic [nr_of_channels_p-1:0]                 cr_pwm_enable,
  input  logic [counter_width_p-1:0]                  cr_fade_step,
  output logic                                        period_start
);

  localparam int W = counter_width_p;
  localparam int N = nr_of_channels_p;
  // Counter stops one short of all-ones so duty = all-ones stays high across the wrap.
  localparam logic [W-1:0] last_count = {{(W-1){1'b1}}, 1'b0};

  logic [W-1:0] counter;
  logic         boundary;
  logic [W-1:0] active_duty [N];
  logic [W-1:0] next_duty   [N];
  logic [N-1:0] active_en;
  logic [N-1:0] raw;

  assign boundary = (counter == last_count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter <= '0;
    end else if (boundary) begin
      counter <= '0;
    end else begin
      counter <= counter + 1'b1;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [W-1:0] target;
    assign target = cr_pwm_duty[i*W +: W];

`ifdef LED_PWM_FADE_EN
    logic [W:0] up_sum;
    logic [W:0] down_lim;

    // Sums are one bit wider so a step past either end saturates at the target.
    always_comb begin
      up_sum       = {1'b0, active_duty[i]} + {1'b0, cr_fade_step};
      down_lim     = {1'b0, target} + {1'b0, cr_fade_step};
      next_duty[i] = target;
      if (!cr_pwm_enable[i]) begin
        next_duty[i] = '0;
      end else if (cr_fade_step == '0) begin
        next_duty[i] = target;
      end else if (active_duty[i] < target) begin
        if (up_sum < {1'b0, target}) begin
          next_duty[i] = up_sum[W-1:0];
        end
      end else if (active_duty[i] > target) begin
        if ({1'b0, active_duty[i]} > down_lim) begin
          next_duty[i] = active_duty[i] - cr_fade_step;
        end
      end
    end
`else
    assign next_duty[i] = target;
`endif
  end

`ifndef LED_PWM_FADE_EN
  logic unused_fade_step;
  assign unused_fade_step = ^cr_fade_step;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_en <= '0;
      for (int i = 0; i < N; i++) begin
        active_duty[i] <= '0;
      end
    end else if (boundary) begin
      active_en <= cr_pwm_enable;
      for (int i = 0; i < N; i++) begin
        active_duty[i] <= next_duty[i];
      end
    end
  end

  always_comb begin
    raw = '0;
    for (int i = 0; i < N; i++) begin
      raw[i] = active_en[i] & (counter < active_duty[i]);
    end
  end

  // Both outputs are registered from the same counter value so they stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm          <= '0;
      period_start <= 1'b0;
    end else begin
      pwm          <= raw;
      period_start <= (counter == '0);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_led_pwm_multi.sv
// tb_led_pwm_multi: counts high cycles per channel in each period window and checks them against queued expectations.
`default_nettype none

module tb_led_pwm_multi;

  localparam int W      = 4;
  localparam int N      = 4;
  localparam int PERIOD = 15;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   pwm;
  logic [N*W-1:0] cr_pwm_duty   = '0;
  logic [N-1:0]   cr_pwm_enable = '0;
  logic [W-1:0]   cr_fade_step  = '0;
  logic           period_start;

  led_pwm_multi #(
    .counter_width_p (W),
    .nr_of_channels_p(N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pwm          (pwm),
    .cr_pwm_duty  (cr_pwm_duty),
    .cr_pwm_enable(cr_pwm_enable),
    .cr_fade_step (cr_fade_step),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] duty;
    logic [3:0]  en;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs [6];
  logic [15:0] exp_q [$];
  logic [15:0] cur_exp;
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one window per period, opened by period_start, closed by the next one.
  bit win_open = 0;
  int win_len  = 0;
  int hi [N];
  int win_idx  = 0;

  task automatic close_window();
    logic [15:0] e;
    check($sformatf("win%0d_len", win_idx), win_len, PERIOD);
    if (exp_q.size() == 0) begin
      check($sformatf("win%0d_has_expectation", win_idx), 0, 1);
    end else begin
      e = exp_q.pop_front();
      for (int c = 0; c < N; c++) begin
        check($sformatf("win%0d_ch%0d_high", win_idx, c), hi[c], int'(e[c*4 +: 4]));
      end
    end
    win_idx++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        win_open = 0;
      end else begin
        if (period_start) begin
          if (win_open) close_window();
          win_open = 1;
          win_len  = 0;
          for (int c = 0; c < N; c++) hi[c] = 0;
        end
        if (win_open) begin
          win_len++;
          for (int c = 0; c < N; c++) if (pwm[c]) hi[c]++;
        end
      end
    end
  end

  task automatic wait_ps();
    bit seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (period_start) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("period_start_timeout", 0, 1);
  endtask

  task automatic push_and_apply(input logic [15:0] duty, input logic [3:0] en,
                                input logic [3:0] step, input logic [15:0] nexp);
    #1 exp_q.push_back(cur_exp);
    repeat (5) @(negedge clk);
    cr_pwm_duty   = duty;
    cr_pwm_enable = en;
    cr_fade_step  = step;
    cur_exp       = nexp;
  endtask

  task automatic next_window(input logic [15:0] duty, input logic [3:0] en,
                             input logic [3:0] step, input logic [15:0] nexp);
    wait_ps();
    push_and_apply(duty, en, step, nexp);
  endtask

  initial begin
    // Duty/expected nibbles are {ch3, ch2, ch1, ch0}.
    vecs[0] = '{duty: 16'hF810, en: 4'hF, exp: 16'hF810};
    vecs[1] = '{duty: 16'hF310, en: 4'hF, exp: 16'hF310};
    vecs[2] = '{duty: 16'hF310, en: 4'hD, exp: 16'hF300};
    vecs[3] = '{duty: 16'h7E25, en: 4'hF, exp: 16'h7E25};
    vecs[4] = '{duty: 16'h7E25, en: 4'h0, exp: 16'h0000};
    vecs[5] = '{duty: 16'hFFFF, en: 4'hF, exp: 16'hFFFF};

    repeat (3) @(negedge clk);
    check("reset_pwm", int'(pwm), 0);
    check("reset_period_start", int'(period_start), 0);
    rst     = 1'b0;
    cur_exp = 16'h0000;

    for (int i = 0; i < 6; i++) begin
      next_window(vecs[i].duty, vecs[i].en, 4'd0, vecs[i].exp);
    end

    // Asynchronous reset in the middle of an all-high window.
    wait_ps();
    repeat (3) @(negedge clk);
    check("pwm_high_before_rst", int'(pwm), 15);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check("pwm_zero_in_rst_cycle", int'(pwm), 0);
    check("ps_zero_in_rst_cycle", int'(period_start), 0);
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    cur_exp = 16'h0000;
    @(negedge clk);
    check("ps_first_cycle_after_release", int'(period_start), 1);
    push_and_apply(16'hFFFF, 4'hF, 4'd0, 16'hFFFF);
    next_window(16'hFFFF, 4'hF, 4'd0, 16'hFFFF);

`ifdef LED_PWM_FADE_EN
    next_window(16'h0000, 4'hF, 4'd0, 16'h0000);
    next_window(16'hFFFF, 4'hF, 4'd4, 16'h4444);
    next_window(16'hFFFF, 4'hF, 4'd4, 16'h8888);
    next_window(16'hFFFF, 4'hF, 4'd4, 16'hCCCC);
    next_window(16'hFFFF, 4'hF, 4'd4, 16'hFFFF);
    next_window(16'h2222, 4'hF, 4'd4, 16'hBBBB);
    next_window(16'h2222, 4'hF, 4'd4, 16'h7777);
    next_window(16'h2222, 4'hF, 4'd4, 16'h3333);
    next_window(16'h2222, 4'hF, 4'd4, 16'h2222);
    next_window(16'h9999, 4'hF, 4'd0, 16'h9999);
    next_window(16'h9999, 4'h0, 4'd0, 16'h0000);
    next_window(16'h9999, 4'hF, 4'd4, 16'h4444);
    next_window(16'h9999, 4'hF, 4'd4, 16'h8888);
    next_window(16'h9999, 4'hF, 4'd4, 16'h9999);
`endif

    wait_ps();
    #1 exp_q.push_back(cur_exp);
    wait_ps();
    #1;
    check("all_windows_consumed", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
